hilo_ctrl: RTL

- Sequencer and HI/LO register owner downstream of the Booth multiplier and the divider.
- Accepts one MULT/DIV/MTHI/MTLO request from the CPU control unit, latches the operands, launches the selected unit and holds busy for stalling.
- Captures the unit's 64-bit result into architectural HI/LO; MFHI/MFLO read hi/lo directly.
- Flags divide-by-zero and units that never report done.

---
 rtl/hilo_pkg.sv | 24 ++
 rtl/hilo_timer.sv | 41 ++++
 rtl/hilo_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared encodings and default sizing for the HI/LO sequencer and its timer.
package hilo_pkg;

  // Default datapath width and wait-state budget; the top exposes both as parameters.
  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefTimeout = 40;

  // Width of the wait counter. TIMEOUT must stay in 1..63 to fit.
  localparam int unsigned CntW = 6;

  // CPU-side operation encodings on the op port.
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  // Sequencer states: idle, or waiting on one of the two arithmetic units.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_MULT = 2'b01,
    WAIT_DIV  = 2'b10
  } state_e;

endpackage

// File: rtl/hilo_timer.sv
// Wait-state counter: cleared while idle, counts up while waiting on a unit, and
// saturates at Timeout so it can never wrap back to a value below the limit.
module hilo_timer
  import hilo_pkg::*;
#(
  parameter int unsigned Timeout = DefTimeout
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CntW-1:0] Limit = CntW'(Timeout);

  logic [CntW-1:0] cnt_d;
  logic [CntW-1:0] cnt_q;

  // Next count: clear wins over enable; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == Limit);

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO owner and launch sequencer for the multiplier and divider. Accepts one
// request in IDLE, latches operands, pulses the unit's go, holds busy until the
// unit reports done (or the wait budget runs out) and copies the result into HI/LO.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] opnd_a,
  output logic [DATA_W-1:0] opnd_b,
  output logic              mult_go,
  output logic              div_go,
  input  logic              mult_done,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  input  logic              div_done,
  input  logic [DATA_W-1:0] div_hi,
  input  logic [DATA_W-1:0] div_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              div_zero,
  output logic              timeout_err
);

  state_e state_d, state_q;

  logic [DATA_W-1:0] hi_d, hi_q;
  logic [DATA_W-1:0] lo_d, lo_q;
  logic [DATA_W-1:0] opnd_a_d, opnd_a_q;
  logic [DATA_W-1:0] opnd_b_d, opnd_b_q;
  logic              mult_go_d, mult_go_q;
  logic              div_go_d, div_go_q;
  logic              busy_d, busy_q;
  logic              div_zero_d, div_zero_q;
  logic              timeout_err_d, timeout_err_q;

  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  hilo_timer #(
    .Timeout (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    opnd_a_d      = opnd_a_q;
    opnd_b_d      = opnd_b_q;
    busy_d        = busy_q;
    mult_go_d     = 1'b0;
    div_go_d      = 1'b0;
    div_zero_d    = 1'b0;
    timeout_err_d = 1'b0;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Keeping the counter cleared here means it reads 0 on the first wait cycle.
        tmr_clr = 1'b1;
        if (start) begin
          unique case (op)
            OP_MULT: begin
              opnd_a_d  = src_a;
              opnd_b_d  = src_b;
              mult_go_d = 1'b1;
              busy_d    = 1'b1;
              state_d   = WAIT_MULT;
            end
            OP_DIV: begin
              if (src_b == '0) begin
                // Never launch the divider on a zero divisor; HI/LO are left alone.
                div_zero_d = 1'b1;
              end else begin
                opnd_a_d = src_a;
                opnd_b_d = src_b;
                div_go_d = 1'b1;
                busy_d   = 1'b1;
                state_d  = WAIT_DIV;
              end
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
          endcase
        end
      end

      WAIT_MULT: begin
        tmr_en = 1'b1;
        // A done on the expiry cycle still counts as a successful completion.
        if (mult_done) begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (tmr_expired) begin
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end
      end

      WAIT_DIV: begin
        tmr_en = 1'b1;
        if (div_done) begin
          hi_d    = div_hi;
          lo_d    = div_lo;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (tmr_expired) begin
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      lo_q          <= '0;
      opnd_a_q      <= '0;
      opnd_b_q      <= '0;
      mult_go_q     <= 1'b0;
      div_go_q      <= 1'b0;
      busy_q        <= 1'b0;
      div_zero_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      opnd_a_q      <= opnd_a_d;
      opnd_b_q      <= opnd_b_d;
      mult_go_q     <= mult_go_d;
      div_go_q      <= div_go_d;
      busy_q        <= busy_d;
      div_zero_q    <= div_zero_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign opnd_a      = opnd_a_q;
  assign opnd_b      = opnd_b_q;
  assign mult_go     = mult_go_q;
  assign div_go      = div_go_q;
  assign busy        = busy_q;
  assign div_zero    = div_zero_q;
  assign timeout_err = timeout_err_q;

  // busy is a registered copy of "not idle"; go pulses only ever open a busy window.
  a_busy_tracks_state: assert property (@(posedge clk) disable iff (!reset)
    busy_q == (state_q != IDLE));
  a_go_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(mult_go_q && div_go_q));
  a_go_implies_busy: assert property (@(posedge clk) disable iff (!reset)
    (mult_go_q || div_go_q) |-> busy_q);

endmodule
